// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between IF and LS.
// LS has fixed priority; a saturating streak counter bounds IF starvation.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_STREAK  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_rdata,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic                ls_req_we,
  input  logic [DATA_W/8-1:0] ls_req_be,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  output logic                ls_rsp_valid,
  output logic [DATA_W-1:0]   ls_rsp_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [2:0] LAST = 3'(MEM_LATENCY - 1);
  localparam logic [3:0] SMAX = 4'(MAX_STREAK);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t     state;
  logic [3:0] streak;
  logic [2:0] wcnt;
  logic       owner_ls;
  logic       op_we;
  logic       idle;
  logic       ls_win;
  logic       if_win;

  // readies are held low while reset is asserted so every output reads 0
  assign idle   = (state == IDLE) & ~rst;
  assign ls_win = ls_req_valid
                & (~if_req_valid | (streak < SMAX));
  assign if_win = if_req_valid & ~ls_win;

  assign ls_req_ready = idle & ls_win;
  assign if_req_ready = idle & if_win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      streak       <= '0;
      wcnt         <= '0;
      owner_ls     <= 1'b0;
      op_we        <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_be       <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      if_rsp_valid <= 1'b0;
      if_rsp_rdata <= '0;
      ls_rsp_valid <= 1'b0;
      ls_rsp_rdata <= '0;
    end else begin
      mem_en       <= 1'b0;
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ls_win) begin
            state     <= ISSUE;
            owner_ls  <= 1'b1;
            op_we     <= ls_req_we;
            mem_en    <= 1'b1;
            mem_we    <= ls_req_we;
            mem_be    <= ls_req_we ? ls_req_be : '1;
            mem_addr  <= ls_req_addr;
            mem_wdata <= ls_req_wdata;
            if (!if_req_valid) begin
              streak <= '0;
            end else if (streak != SMAX) begin
              streak <= streak + 4'd1;
            end
          end else if (if_win) begin
            state    <= ISSUE;
            owner_ls <= 1'b0;
            op_we    <= 1'b0;
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_be   <= '1;
            mem_addr <= if_req_addr;
            streak   <= '0;
          end
        end
        ISSUE: begin
          wcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (wcnt == LAST) begin
            state <= RESP;
            if (owner_ls) begin
              ls_rsp_valid <= 1'b1;
              ls_rsp_rdata <= op_we ? '0 : mem_rdata;
            end else begin
              if_rsp_valid <= 1'b1;
              if_rsp_rdata <= mem_rdata;
            end
          end else begin
            wcnt <= wcnt + 3'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
